c3s4_layer_ctrl: RTL and testbench

Sequencing FSM for the C3/S4 convolution plus max-pool datapath. For each kernel and each pooled output it walks the four 2x2 pool-window anchors. Per anchor it drives the anchor ROM address, fetches five 5-word rows into the 25-word window buffer and hands the window to the shared MAC unit. It captures each result into a 4-entry pool slot, then commands the pooled word write to the output buffer. It sits between layer-level enable logic and the address generator, window buffer, calc unit and pool register.

---
 rtl/c3s4_layer_ctrl.sv | 153 +++++++++++++++
 tb/tb_c3s4_layer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/c3s4_layer_ctrl.sv
// c3s4_layer_ctrl: C3/S4 conv + max-pool sequencer walking kernels, pooled outputs and 2x2 anchors.
// Optional C3S4_CALC_TIMEOUT_EN aborts the layer when the MAC result never arrives.
module c3s4_layer_ctrl #(
  parameter int NUM_KERNEL  = 16,
  parameter int POOL_OUT_N  = 25,
  parameter int ROM_LAT     = 1,
  parameter int ANCHOR_AW   = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 layer_en_i,
  input  logic                 calc_done_i,
  output logic                 layer_busy_o,
  output logic                 layer_done_o,
  output logic                 output_buf_en_o,
  output logic [7:0]           kernel_idx_o,
  output logic [ANCHOR_AW-1:0] anchor_addr_o,
  output logic                 row_fetch_en_o,
  output logic [2:0]           row_idx_o,
  output logic                 calc_start_o,
  output logic [1:0]           pool_slot_o,
  output logic                 pool_capture_o,
  output logic                 out_wr_en_o,
  output logic [31:0]          out_wr_addr_o,
  output logic                 error_o
);
  localparam int PW = POOL_OUT_N > 1 ? $clog2(POOL_OUT_N) : 1;
  localparam int LW = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
  typedef enum logic [2:0] {IDLE, ANCHOR, FETCH, CALC, WAIT, POOL, WRITE, DONE} state_t;
  state_t state;
  logic [PW-1:0] p;
  logic [1:0] q;
  logic [LW-1:0] lat;
`ifdef C3S4_CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
`else
  assign error_o = 1'b0;
`endif
  assign output_buf_en_o = layer_busy_o;
  // Outputs are loaded on the transition into the state they belong to, so each is visible exactly while that state is current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      p              <= '0;
      q              <= '0;
      lat            <= '0;
      layer_busy_o   <= 1'b0;
      layer_done_o   <= 1'b0;
      kernel_idx_o   <= '0;
      anchor_addr_o  <= '0;
      row_fetch_en_o <= 1'b0;
      row_idx_o      <= '0;
      calc_start_o   <= 1'b0;
      pool_slot_o    <= '0;
      pool_capture_o <= 1'b0;
      out_wr_en_o    <= 1'b0;
      out_wr_addr_o  <= '0;
`ifdef C3S4_CALC_TIMEOUT_EN
      tcnt           <= '0;
      error_o        <= 1'b0;
`endif
    end else begin
      row_fetch_en_o <= 1'b0;
      calc_start_o   <= 1'b0;
      pool_capture_o <= 1'b0;
      out_wr_en_o    <= 1'b0;
      layer_done_o   <= 1'b0;
`ifdef C3S4_CALC_TIMEOUT_EN
      error_o        <= 1'b0;
`endif
      case (state)
        IDLE: if (layer_en_i) begin
          state         <= ANCHOR;
          layer_busy_o  <= 1'b1;
          kernel_idx_o  <= '0;
          anchor_addr_o <= '0;
          p             <= '0;
          q             <= '0;
          lat           <= '0;
        end
        ANCHOR: if (lat == LW'(ROM_LAT - 1)) begin
          state          <= FETCH;
          row_fetch_en_o <= 1'b1;
          row_idx_o      <= '0;
        end else lat <= lat + 1'b1;
        FETCH: if (row_idx_o == 3'd4) begin
          state        <= CALC;
          calc_start_o <= 1'b1;
          row_idx_o    <= '0;
        end else begin
          row_fetch_en_o <= 1'b1;
          row_idx_o      <= row_idx_o + 3'd1;
        end
        CALC: begin
          state <= WAIT;
`ifdef C3S4_CALC_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: if (calc_done_i) begin
          state          <= POOL;
          pool_capture_o <= 1'b1;
          pool_slot_o    <= q;
        end
`ifdef C3S4_CALC_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          state         <= IDLE;
          error_o       <= 1'b1;
          layer_busy_o  <= 1'b0;
          kernel_idx_o  <= '0;
          anchor_addr_o <= '0;
          p             <= '0;
          q             <= '0;
        end else tcnt <= tcnt + 1'b1;
`endif
        POOL: begin
          lat <= '0;
          if (q == 2'd3) begin
            state         <= WRITE;
            q             <= '0;
            out_wr_en_o   <= 1'b1;
            out_wr_addr_o <= 32'(kernel_idx_o) * 32'(POOL_OUT_N) + 32'(p);
          end else begin
            state         <= ANCHOR;
            q             <= q + 2'd1;
            anchor_addr_o <= anchor_addr_o + ANCHOR_AW'(1);
          end
        end
        // Anchor p*4+3 plus one is the first anchor of p+1.
        WRITE: if (p != PW'(POOL_OUT_N - 1)) begin
          state         <= ANCHOR;
          p             <= p + 1'b1;
          anchor_addr_o <= anchor_addr_o + ANCHOR_AW'(1);
        end else if (kernel_idx_o != 8'(NUM_KERNEL - 1)) begin
          state         <= ANCHOR;
          p             <= '0;
          kernel_idx_o  <= kernel_idx_o + 8'd1;
          anchor_addr_o <= '0;
        end else begin
          state        <= DONE;
          layer_done_o <= 1'b1;
        end
        DONE: begin
          state        <= IDLE;
          layer_busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c3s4_layer_ctrl.sv
// tb_c3s4_layer_ctrl: directed self-checking bench for c3s4_layer_ctrl (default and boundary parameter instances).
module tb_c3s4_layer_ctrl;
  logic clk = 0, rst = 1, layer_en_i = 0, calc_done_i = 0, en2 = 0, done2 = 0;
  logic busy, ldone, obuf, fetch, cstart, pcap, wr, err;
  logic [7:0] kidx;
  logic [9:0] anchor;
  logic [2:0] ridx;
  logic [1:0] slot;
  logic [31:0] waddr;
  logic b_busy, b_done, b_obuf, b_fetch, b_cstart, b_pcap, b_wr, b_err;
  logic [7:0] b_kidx;
  logic [9:0] b_anchor;
  logic [2:0] b_ridx;
  logic [1:0] b_slot;
  logic [31:0] b_waddr;
  int checks = 0, failures = 0, cyc = 0;
  int ncalc = 0, stall_idx = -1, stall_len = 0, wcnt = 0;
  logic pend = 0, auto_done = 1, spur = 0, cs2_prev = 0;

  always #5 clk = ~clk;

  c3s4_layer_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .layer_en_i(layer_en_i), .calc_done_i(calc_done_i),
    .layer_busy_o(busy), .layer_done_o(ldone), .output_buf_en_o(obuf), .kernel_idx_o(kidx),
    .anchor_addr_o(anchor), .row_fetch_en_o(fetch), .row_idx_o(ridx), .calc_start_o(cstart),
    .pool_slot_o(slot), .pool_capture_o(pcap), .out_wr_en_o(wr), .out_wr_addr_o(waddr), .error_o(err));

  c3s4_layer_ctrl #(.NUM_KERNEL(1), .POOL_OUT_N(1), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .layer_en_i(en2), .calc_done_i(done2),
    .layer_busy_o(b_busy), .layer_done_o(b_done), .output_buf_en_o(b_obuf), .kernel_idx_o(b_kidx),
    .anchor_addr_o(b_anchor), .row_fetch_en_o(b_fetch), .row_idx_o(b_ridx), .calc_start_o(b_cstart),
    .pool_slot_o(b_slot), .pool_capture_o(b_pcap), .out_wr_en_o(b_wr), .out_wr_addr_o(b_waddr), .error_o(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; the MAC model answers in the cycle after calc_start, optionally stalled.
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    calc_done_i = 0;
    if (pend) begin
      if (wcnt == 0) begin
        calc_done_i = 1;
        pend = 0;
      end else wcnt--;
    end
    if (cstart) begin
      pend = auto_done;
      wcnt = (ncalc == stall_idx) ? stall_len : 0;
      ncalc++;
    end
    if (spur && fetch) calc_done_i = 1;
    done2 = cs2_prev;
    cs2_prev = b_cstart;
  endtask

  task automatic start;
    ncalc = 0;
    pend = 0;
    layer_en_i = 1;
    cyc = 0;
    step;
    layer_en_i = 0;
  endtask

  initial begin
    int nwr, npool, err_cyc, ffetch, fpool, wcyc, dcyc, nwr2;
    int pexp[4];
    pexp = '{9, 18, 37, 46};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_obuf", 32'(obuf), 0);
    chk("rst_done", 32'(ldone), 0);
    chk("rst_anchor", 32'(anchor), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    step;
    // Full layer with immediate calc_done and a start pulse while busy.
    start;
    nwr = 0;
    while (!ldone && cyc < 16000) begin
      if (cyc <= 37) begin
        chk("fetch_pat", 32'(fetch), 32'(cyc % 9 >= 2 && cyc % 9 <= 6));
        chk("cstart_pat", 32'(cstart), 32'(cyc % 9 == 7));
        chk("pcap_pat", 32'(pcap), 32'(cyc % 9 == 0));
        chk("busy_pat", 32'(busy), 1);
      end
      if (cyc >= 2 && cyc <= 6) chk("row_idx", 32'(ridx), 32'(cyc - 2));
      if (pcap && cyc <= 36) chk("slot", 32'(slot), 32'(cyc / 9 - 1));
      if (cyc == 1) chk("anchor_c1", 32'(anchor), 0);
      if (cyc == 38) chk("anchor_c38", 32'(anchor), 4);
      if (wr) begin
        chk("wr_addr", waddr, 32'(nwr));
        chk("wr_cyc", 32'(cyc), 32'(37 * (nwr + 1)));
        chk("wr_kidx", 32'(kidx), 32'(nwr / 25));
        nwr++;
      end
      layer_en_i = (cyc == 100);
      step;
    end
    chk("done_cyc", 32'(cyc), 14801);
    chk("done_pulse", 32'(ldone), 1);
    chk("n_writes", 32'(nwr), 400);
    step;
    chk("done_single", 32'(ldone), 0);
    chk("idle_busy", 32'(busy), 0);
    // Stall the q=2 calc by 10 cycles, with spurious calc_done during FETCH.
    stall_idx = 2;
    stall_len = 10;
    spur = 1;
    start;
    npool = 0;
    while (!wr && cyc < 80) begin
      if (pcap) begin
        chk("stall_slot", 32'(slot), 32'(npool));
        chk("stall_pcyc", 32'(cyc), 32'(pexp[npool]));
        npool++;
      end
      step;
    end
    chk("stall_wr_cyc", 32'(cyc), 47);
    chk("stall_wr_addr", waddr, 0);
    chk("stall_npool", 32'(npool), 4);
    while (!fetch && cyc < 120) step;
    chk("pre_rst_fetch", 32'(fetch), 1);
    rst = 1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fetch", 32'(fetch), 0);
    step;
    chk("rst_edge_busy", 32'(busy), 0);
    chk("rst_edge_obuf", 32'(obuf), 0);
    chk("rst_edge_anchor", 32'(anchor), 0);
    chk("rst_edge_ridx", 32'(ridx), 0);
    rst = 0;
    spur = 0;
    stall_idx = -1;
    step;
    start;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_anchor", 32'(anchor), 0);
    chk("restart_kidx", 32'(kidx), 0);
    step;
    chk("restart_fetch", 32'(fetch), 1);
    chk("restart_ridx", 32'(ridx), 0);
    rst = 1;
    step;
    rst = 0;
    step;
    // Calc result never arrives.
    auto_done = 0;
    start;
    err_cyc = 0;
    nwr = 0;
    while (cyc < 30) begin
      if (err && err_cyc == 0) err_cyc = cyc;
      if (wr || ldone) nwr++;
      step;
    end
    chk("to_no_write", 32'(nwr), 0);
`ifdef C3S4_CALC_TIMEOUT_EN
    chk("to_err_cyc", 32'(err_cyc), 12);
    chk("to_idle", 32'(busy), 0);
`else
    chk("to_no_err", 32'(err_cyc), 0);
    chk("to_still_busy", 32'(busy), 1);
`endif
    rst = 1;
    step;
    rst = 0;
    auto_done = 1;
    step;
    // Boundary instance: one kernel, one output, ROM_LAT=3.
    en2 = 1;
    cyc = 0;
    step;
    en2 = 0;
    ffetch = 0; fpool = 0; wcyc = 0; dcyc = 0; nwr2 = 0;
    while (cyc < 60) begin
      if (b_fetch && ffetch == 0) ffetch = cyc;
      if (b_pcap && fpool == 0) fpool = cyc;
      if (b_wr) begin
        nwr2++;
        wcyc = cyc;
        chk("b_wr_addr", b_waddr, 0);
      end
      if (b_done) dcyc = cyc;
      step;
    end
    chk("b_first_fetch", 32'(ffetch), 4);
    chk("b_first_pool", 32'(fpool), 11);
    chk("b_n_writes", 32'(nwr2), 1);
    chk("b_wr_cyc", 32'(wcyc), 45);
    chk("b_done_cyc", 32'(dcyc), 46);
    chk("b_idle", 32'(b_busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
